// File: rtl/automata_report_pkg.sv
`default_nettype none
// ============================================================================
// Module      : automata_report_pkg
// Description : Shared types and constants for the automaton report
//               collector: record layout, collector FSM state encoding,
//               drop-counter width and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package automata_report_pkg;

    localparam int DROP_CNT_W   = 16;

    // Record layout at the default collector geometry. The collector itself
    // packs {offset, report} in this same order for any parameterisation.
    localparam int REC_OFFSET_W = 32;
    localparam int REC_REPORT_W = 4;

    typedef struct packed {
        logic [REC_OFFSET_W-1:0] offset;
        logic [REC_REPORT_W-1:0] report;
    } report_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } collector_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/report_fifo.sv
`default_nettype none
// ============================================================================
// Module      : report_fifo
// Description : Synchronous FIFO built from flops. The head entry is read
//               straight out of the storage flops, so a record pushed on an
//               edge is visible at the output right after that edge.
//               A push into a full FIFO succeeds only if a pop happens on the
//               same edge; otherwise it is discarded (caller counts drops).
// Ports       : clk, reset_n   - clock, async active-low reset
//               push/push_data - write request and data
//               pop            - consume head entry (ignored when empty)
//               head_data      - current head entry
//               full/empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module report_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_full);
    assign head_data = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    // When full, the write slot equals the head slot being popped this edge,
    // so overwriting it is safe.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/automata_report_collector.sv
`default_nettype none
// ============================================================================
// Module      : automata_report_collector
// Description : Captures report-STE activations from an NFA cluster, tags
//               each non-zero report vector with the offset of the symbol
//               that produced it, and queues the records for a valid/ready
//               consumer. Overflowing records are dropped and counted.
// Ports       : clk, reset_n             - clock, async active-low reset
//               start                    - begin a new stream
//               sym_valid, sym_last      - symbol strobe / end of stream
//               report                   - automaton report outputs
//               rec_valid/ready/offset/report - record output handshake
//               busy, done               - stream / drain status
//               overflow, drop_count     - drop reporting
// Revision    : 1.0 - initial release
// ============================================================================
module automata_report_collector
    import automata_report_pkg::*;
#(
    parameter int NUM_REPORTS = 4,
    parameter int OFFSET_W    = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int REPORT_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   sym_valid,
    input  logic                   sym_last,
    input  logic [NUM_REPORTS-1:0] report,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [OFFSET_W-1:0]    rec_offset,
    output logic [NUM_REPORTS-1:0] rec_report,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_count
);

    localparam int c_rec_w = OFFSET_W + NUM_REPORTS;

    collector_state_t r_state;
    collector_state_t w_state_nxt;

    logic [OFFSET_W-1:0]   r_offset;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_count;

    logic                  w_sym_acc;
    logic                  w_d_valid;
    logic                  w_d_last;
    logic [OFFSET_W-1:0]   w_d_offset;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_rec_w-1:0]    w_head;

    // A symbol only counts while a stream is active; start takes priority
    // and re-bases the stream, so a symbol coincident with it is discarded.
    assign w_sym_acc = sym_valid && (r_state == ST_ACTIVE) && !start;

    // Delay symbol qualifiers and offset so they line up with the report
    // bits the automaton produces REPORT_LAT cycles later.
    generate
        if (REPORT_LAT == 0) begin : g_no_delay
            assign w_d_valid  = w_sym_acc;
            assign w_d_last   = w_sym_acc && sym_last;
            assign w_d_offset = r_offset;
        end else begin : g_delay
            logic [REPORT_LAT-1:0] r_valid_pipe;
            logic [REPORT_LAT-1:0] r_last_pipe;
            logic [OFFSET_W-1:0]   r_off_pipe [REPORT_LAT];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid_pipe <= '0;
                    r_last_pipe  <= '0;
                    for (int i = 0; i < REPORT_LAT; i++) begin
                        r_off_pipe[i] <= '0;
                    end
                end else begin
                    for (int i = REPORT_LAT - 1; i > 0; i--) begin
                        r_valid_pipe[i] <= r_valid_pipe[i-1];
                        r_last_pipe[i]  <= r_last_pipe[i-1];
                        r_off_pipe[i]   <= r_off_pipe[i-1];
                    end
                    r_valid_pipe[0] <= w_sym_acc;
                    r_last_pipe[0]  <= w_sym_acc && sym_last;
                    r_off_pipe[0]   <= r_offset;
                    // Symbols of an abandoned stream must not leak into the new one.
                    if (start) begin
                        r_valid_pipe <= '0;
                        r_last_pipe  <= '0;
                    end
                end
            end

            assign w_d_valid  = r_valid_pipe[REPORT_LAT-1];
            assign w_d_last   = r_last_pipe[REPORT_LAT-1];
            assign w_d_offset = r_off_pipe[REPORT_LAT-1];
        end
    endgenerate

    assign w_pop  = rec_valid && rec_ready;
    assign w_push = w_d_valid && (report != '0);
    assign w_drop = w_push && w_fifo_full && !w_pop;

    report_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data ({w_d_offset, report}),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign rec_valid  = !w_fifo_empty;
    assign rec_offset = w_head[c_rec_w-1:NUM_REPORTS];
    assign rec_report = w_head[NUM_REPORTS-1:0];
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_offset     <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                r_offset     <= '0;
                r_overflow   <= 1'b0;
                r_drop_count <= '0;
            end else begin
                if (w_sym_acc) begin
                    r_offset <= r_offset + 1'b1;
                end
                if (w_drop) begin
                    r_overflow   <= 1'b1;
                    r_drop_count <= sat_inc(r_drop_count);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        if (start) begin
            w_state_nxt = ST_ACTIVE;
        end else begin
            case (r_state)
                ST_ACTIVE: if (w_d_valid && w_d_last) w_state_nxt = ST_DRAIN;
                ST_DRAIN:  if (w_fifo_empty)          w_state_nxt = ST_DONE;
                default:   w_state_nxt = r_state;
            endcase
        end
        busy = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN) || !w_fifo_empty;
        done = (r_state == ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_automata_report_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_automata_report_collector
// Description : Self-checking bench for automata_report_collector. The bench
//               plays the automaton (reports lag symbols by one cycle) and
//               keeps a queue-based reference of the record stream, the
//               stream status and the drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_automata_report_collector;

    localparam int NR    = 4;
    localparam int OW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          sym_valid;
    logic          sym_last;
    logic [NR-1:0] report;
    logic          rec_valid;
    logic          rec_ready;
    logic [OW-1:0] rec_offset;
    logic [NR-1:0] rec_report;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [15:0]   drop_count;

    automata_report_collector #(
        .NUM_REPORTS (NR),
        .OFFSET_W    (OW),
        .FIFO_DEPTH  (DEPTH),
        .REPORT_LAT  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .sym_valid  (sym_valid),
        .sym_last   (sym_last),
        .report     (report),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_offset (rec_offset),
        .rec_report (rec_report),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [OW-1:0] off;
        logic [NR-1:0] rep;
    } rec_t;

    // Reference model state
    rec_t          mq[$];      // records expected in the buffer, head first
    rec_t          got[$];     // records actually transferred by the DUT
    int            m_offset;
    bit            m_started, m_last_seen, m_ended, m_done, m_ovf;
    int            m_drops;
    bit            pend_valid, pend_last;
    logic [OW-1:0] pend_off;
    logic [NR-1:0] carried_rep;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_offset    = 0;
        m_started   = 0;
        m_last_seen = 0;
        m_ended     = 0;
        m_done      = 0;
        m_ovf       = 0;
        m_drops     = 0;
        pend_valid  = 0;
        pend_last   = 0;
        pend_off    = '0;
        carried_rep = '0;
    endtask

    task automatic check_all();
        chk("rec_valid", rec_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("rec_offset", rec_offset, mq[0].off);
            chk("rec_report", rec_report, mq[0].rep);
        end
        chk("busy",       busy, (m_started && !m_done) || (mq.size() > 0));
        chk("done",       done, m_done);
        chk("overflow",   overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
    endtask

    // One clock cycle: drive at the falling edge, advance the reference
    // model across the rising edge, check at the next falling edge.
    // 'rep' is the automaton's answer to this cycle's symbol; it appears on
    // the report bus one cycle later.
    task automatic cycle(input bit sv, input bit sl, input logic [NR-1:0] rep,
                         input bit rdy, input bit st);
        bit pop, push, pre_empty, acc;
        start       = st;
        sym_valid   = sv;
        sym_last    = sl;
        rec_ready   = rdy;
        report      = carried_rep;
        carried_rep = rep;
        #1;
        if (rec_valid && rec_ready) got.push_back({rec_offset, rec_report});

        pre_empty = (mq.size() == 0);
        pop       = (mq.size() > 0) && rdy;
        push      = pend_valid && (report != '0);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() >= DEPTH) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end else begin
                mq.push_back({pend_off, report});
            end
        end
        if (st) begin
            m_started   = 1;
            m_last_seen = 0;
            m_ended     = 0;
            m_done      = 0;
            m_ovf       = 0;
            m_drops     = 0;
            m_offset    = 0;
            pend_valid  = 0;
            pend_last   = 0;
        end else begin
            if (m_ended && !m_done && pre_empty) m_done = 1;
            if (pend_valid && pend_last) m_ended = 1;
            acc        = sv && m_started && !m_last_seen;
            pend_valid = acc;
            pend_last  = acc && sl;
            pend_off   = OW'(m_offset);
            if (acc) begin
                m_offset++;
                if (sl) m_last_seen = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drain(input int max_cycles);
        for (int n = 0; n < max_cycles && !(m_done && mq.size() == 0); n++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        report    = '0;
        rec_ready = 1'b0;
        model_reset();
        got.delete();
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_rec_offset", rec_offset, 0);
        chk("rst_rec_report", rec_report, 0);
        check_all();
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 4'hF, 1'b1, 1'b0);   // symbol in IDLE is ignored
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Single report at symbol 3
        got.delete();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, i == 4, (i == 3) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
        end
        drain(10);
        chk("single_count",  got.size(), 1);
        chk("single_offset", got[0].off, 3);
        chk("single_report", got[0].rep, 4'b0010);
        chk("single_done",   done, 1);
        chk("single_drops",  drop_count, 0);

        // Several report bits on one symbol -> one record
        got.delete();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 4'b1011, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
        drain(10);
        chk("multi_count",  got.size(), 1);
        chk("multi_offset", got[0].off, 0);
        chk("multi_report", got[0].rep, 4'b1011);

        // Overflow: 20 reporting symbols with the consumer stalled
        got.delete();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, i == 19, NR'($urandom_range(1, 15)), 1'b0, 1'b0);
        end
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("ovf_drops", drop_count, 4);
        chk("ovf_flag",  overflow, 1);
        drain(40);
        chk("ovf_count", got.size(), 16);
        for (int i = 0; i < 16; i++) chk("ovf_order", got[i].off, i);

        // Full FIFO with push and pop on the same edge -> no drop
        got.delete();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, i == 16, NR'($urandom_range(1, 15)), 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);    // symbol 16's record meets a pop
        chk("pp_drops", drop_count, 0);
        chk("pp_flag",  overflow, 0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drain(40);
        chk("pp_count", got.size(), 17);
        for (int i = 0; i < 17; i++) chk("pp_order", got[i].off, i);

        // Offset wrap: 258 symbols, report on symbol 257 -> offset 1
        got.delete();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 258; i++) begin
            cycle(1'b1, i == 257, (i == 257) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
        end
        drain(10);
        chk("wrap_count",  got.size(), 1);
        chk("wrap_offset", got[0].off, 1);

        // Randomised streams with gaps, stray symbols and random backpressure
        for (int s = 0; s < 6; s++) begin
            int len;
            int noise;
            bit sv;
            len = $urandom_range(5, 40);
            cycle(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)), 1'b1);
            for (int k = 0; k < len; k++) begin
                sv = (k == len - 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (sv)
                    cycle(1'b1, k == len - 1,
                          ($urandom_range(0, 9) < 3) ? NR'($urandom_range(1, 15)) : '0,
                          1'($urandom_range(0, 1)), 1'b0);
                else
                    cycle(1'b0, 1'b0, NR'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            end
            repeat (2) cycle(1'b0, 1'b0, NR'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            noise = $urandom_range(0, 4);
            for (int k = 0; k < noise; k++) begin
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      NR'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            end
            if ((s % 2) == 0 || s == 5) drain(80);
        end

        // Asynchronous reset with three records buffered
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, (i < 3) ? NR'($urandom_range(1, 15)) : '0, 1'b0, 1'b0);
        end
        chk("pre_rst_valid", rec_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rec_valid",  rec_valid, 0);
        chk("arst_busy",       busy, 0);
        chk("arst_done",       done, 0);
        chk("arst_overflow",   overflow, 0);
        chk("arst_drop_count", drop_count, 0);
        chk("arst_rec_offset", rec_offset, 0);
        chk("arst_rec_report", rec_report, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'b0, NR'($urandom_range(0, 15)), 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
